fir_mc: RTL and testbench

Parametrised, time-multiplexed multi-channel FIR filter; successor to the single-channel 16-tap `fir`. It uses one shared multiply-accumulate unit and keeps a per-channel circular delay line. Coefficients are written and read through a plain write/read port instead of a bidirectional bus. It sits between the sample front-end and downstream decimation/logging, with a valid/ready handshake on input and a valid pulse on output.

---
 rtl/fir_mc_if.sv | 36 +++
 rtl/fir_mc.sv | 146 ++++++++++++++
 tb/tb_fir_mc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fir_mc_if.sv
// Sample/result handshake and coefficient port of the multi-channel FIR (fir_mc).
// The slave modport is the filter side; the master modport is the producer/host side.
interface fir_mc_if #(
   parameter int DATA_W   = 16,
   parameter int COEFF_W  = 16,
   parameter int TAPS     = 16,
   parameter int CHANNELS = 2,
   parameter int OUT_W    = 32
);
   localparam int AW = $clog2(TAPS);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                      valid_i;
   logic                      ready_o;
   logic [CW-1:0]             chan_i;
   logic signed [DATA_W-1:0]  data_i;
   logic                      valid_o;
   logic [CW-1:0]             chan_o;
   logic signed [OUT_W-1:0]   data_o;
   logic                      coeff_we_i;
   logic [AW-1:0]             coeff_addr_i;
   logic signed [COEFF_W-1:0] coeff_wdata_i;
   logic signed [COEFF_W-1:0] coeff_rdata_o;
   logic                      coeff_drop_o;
   logic                      chan_err_o;

   modport master (
      output valid_i, chan_i, data_i, coeff_we_i, coeff_addr_i, coeff_wdata_i,
      input  ready_o, valid_o, chan_o, data_o, coeff_rdata_o, coeff_drop_o, chan_err_o
   );

   modport slave (
      input  valid_i, chan_i, data_i, coeff_we_i, coeff_addr_i, coeff_wdata_i,
      output ready_o, valid_o, chan_o, data_o, coeff_rdata_o, coeff_drop_o, chan_err_o
   );
endinterface

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC, per-channel circular delay lines.
// Define FIR_MC_SAT_EN for round-half-up plus saturation on output; default wraps to OUT_W.
//
// state  | meaning
// IDLE   | ready for a sample; coefficient writes accepted
// MAC    | one tap per cycle, k = 0..TAPS-1
// OUT    | register result, pulse valid_o, advance channel write pointer
module fir_mc #(
   parameter int DATA_W   = 16,
   parameter int COEFF_W  = 16,
   parameter int TAPS     = 16,
   parameter int CHANNELS = 2,
   parameter int ACC_W    = DATA_W + COEFF_W + $clog2(TAPS),
   parameter int OUT_W    = 32,
   parameter int SHIFT    = 0
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   fir_mc_if.slave  bus
);
   localparam int AW = $clog2(TAPS);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PW = DATA_W + COEFF_W;
   localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNELS);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                                     state_q, state_d;
   logic [AW-1:0]                              k_q;
   logic [CW-1:0]                              ch_q;
   logic signed [ACC_W-1:0]                    acc_q;
   logic [TAPS-1:0][COEFF_W-1:0]               coeff_q;
   logic [CHANNELS-1:0][TAPS-1:0][DATA_W-1:0]  x_q;
   logic [CHANNELS-1:0][AW-1:0]                wp_q;

   logic                      chan_ok, accept, coeff_wr, ready;
   logic [AW-1:0]             rp, wp_cur;
   logic signed [PW-1:0]      prod;
   logic signed [OUT_W-1:0]   res;

   logic                      valid_q, drop_q, err_q;
   logic [CW-1:0]             chan_out_q;
   logic signed [OUT_W-1:0]   data_q;
   logic signed [COEFF_W-1:0] rdata_q;

   assign chan_ok  = {1'b0, bus.chan_i} < CH_LIM;
   assign accept   = (state_q == S_IDLE) && bus.valid_i && chan_ok;
   assign coeff_wr = (state_q == S_IDLE) && bus.coeff_we_i;

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (accept) state_d = S_MAC;
         end
         S_MAC:   if (k_q == AW'(TAPS - 1)) state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Newest sample is at wp during MAC; tap k reads wp-k modulo TAPS.
   assign wp_cur = wp_q[ch_q];
   always_comb begin
      rp = wp_cur - k_q;
      if (wp_cur < k_q) rp = rp + AW'(TAPS);
   end

   assign prod = PW'($signed(coeff_q[k_q])) * PW'($signed(x_q[ch_q][rp]));

`ifdef FIR_MC_SAT_EN
   localparam logic signed [ACC_W:0] RND =
      (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACC_W:0] O_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] O_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
   logic signed [ACC_W:0] shf;

   always_comb begin
      shf = ((ACC_W+1)'(acc_q) + RND) >>> SHIFT;
      res = shf[OUT_W-1:0];
      if (shf > O_MAX)      res = O_MAX[OUT_W-1:0];
      else if (shf < O_MIN) res = O_MIN[OUT_W-1:0];
   end
`else
   assign res = OUT_W'(acc_q >>> SHIFT);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q        <= '0;
         ch_q       <= '0;
         acc_q      <= '0;
         valid_q    <= 1'b0;
         chan_out_q <= '0;
         data_q     <= '0;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         valid_q <= (state_q == S_OUT);
         drop_q  <= bus.coeff_we_i && (state_q != S_IDLE);
         err_q   <= (state_q == S_IDLE) && bus.valid_i && !chan_ok;
         rdata_q <= coeff_wr ? bus.coeff_wdata_i : $signed(coeff_q[bus.coeff_addr_i]);
         if (accept) begin
            ch_q  <= bus.chan_i;
            acc_q <= '0;
            k_q   <= '0;
         end else if (state_q == S_MAC) begin
            acc_q <= acc_q + ACC_W'(prod);
            k_q   <= k_q + AW'(1);
         end
         if (state_q == S_OUT) begin
            data_q     <= res;
            chan_out_q <= ch_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         coeff_q <= '0;
         x_q     <= '0;
         wp_q    <= '0;
      end else begin
         if (coeff_wr) coeff_q[bus.coeff_addr_i] <= bus.coeff_wdata_i;
         if (accept)   x_q[bus.chan_i][wp_q[bus.chan_i]] <= bus.data_i;
         if (state_q == S_OUT)
            wp_q[ch_q] <= (wp_cur == AW'(TAPS - 1)) ? '0 : wp_cur + AW'(1);
      end
   end

   assign bus.ready_o       = ready;
   assign bus.valid_o       = valid_q;
   assign bus.chan_o        = chan_out_q;
   assign bus.data_o        = data_q;
   assign bus.coeff_rdata_o = rdata_q;
   assign bus.coeff_drop_o  = drop_q;
   assign bus.chan_err_o    = err_q;
endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc: vector table for impulse/isolation, hand sequences for corner cases.
// Built with CHANNELS=3 so an out-of-range channel code (3) is representable on chan_i.
`timescale 1ns/1ps
module tb_fir_mc;
   localparam int TAPS = 16;
   localparam int CHANNELS = 3;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   fir_mc_if #(.DATA_W(16), .COEFF_W(16), .TAPS(TAPS), .CHANNELS(CHANNELS), .OUT_W(32)) bus ();

   fir_mc #(.DATA_W(16), .COEFF_W(16), .TAPS(TAPS), .CHANNELS(CHANNELS),
            .OUT_W(32), .SHIFT(0)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   typedef struct {
      logic [1:0]          chan;
      logic signed [15:0]  data;
      logic signed [31:0]  exp;
   } vec_t;

   vec_t vecs [49];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic write_coeff(input logic [3:0] a, input logic signed [15:0] v);
      @(negedge clk_i);
      bus.coeff_we_i = 1'b1; bus.coeff_addr_i = a; bus.coeff_wdata_i = v;
      @(posedge clk_i); #1;
      bus.coeff_we_i = 1'b0;
   endtask

   task automatic send(input logic [1:0] ch, input logic signed [15:0] d);
      int w = 0;
      @(negedge clk_i);
      while (!bus.ready_o && w < 40) begin @(negedge clk_i); w++; end
      if (!bus.ready_o) chk("ready_timeout", 64'(bus.ready_o), 64'd1);
      bus.valid_i = 1'b1; bus.chan_i = ch; bus.data_i = d;
      @(posedge clk_i); #1;
      bus.valid_i = 1'b0;
   endtask

   task automatic wait_out(input int start, input logic [1:0] ch, input logic signed [31:0] e,
                           input bit full, input string name);
      int cyc = start;
      do begin @(posedge clk_i); #1; cyc++; end while (!bus.valid_o && cyc < 40);
      if (full) begin
         chk({name, "_lat"},  64'(cyc), 64'(TAPS + 1));
         chk({name, "_data"}, 64'(bus.data_o), 64'(e));
         chk({name, "_chan"}, 64'(bus.chan_o), 64'(ch));
      end else begin
         chk({name, "_valid"}, 64'(bus.valid_o), 64'd1);
      end
   endtask

   task automatic no_valid_for(input int n, input string name);
      bit saw = 1'b0;
      repeat (n) begin @(posedge clk_i); #1; if (bus.valid_o) saw = 1'b1; end
      chk(name, 64'(saw), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.valid_i = 1'b0; bus.chan_i = '0; bus.data_i = '0;
      bus.coeff_we_i = 1'b0; bus.coeff_addr_i = '0; bus.coeff_wdata_i = '0;

      // impulse on ch0 with c[k]=k+1, then interleaved ch0=100 / ch1=-3 impulses
      for (int i = 0; i < 17; i++) begin
         vecs[i].chan = 2'd0;
         vecs[i].data = (i == 0) ? 16'sd1 : 16'sd0;
         vecs[i].exp  = (i < 16) ? 32'(i + 1) : 32'sd0;
      end
      for (int j = 0; j < 16; j++) begin
         vecs[17 + 2*j].chan = 2'd0;
         vecs[17 + 2*j].data = (j == 0) ? 16'sd100 : 16'sd0;
         vecs[17 + 2*j].exp  = 32'(100 * (j + 1));
         vecs[18 + 2*j].chan = 2'd1;
         vecs[18 + 2*j].data = (j == 0) ? -16'sd3 : 16'sd0;
         vecs[18 + 2*j].exp  = 32'(-3 * (j + 1));
      end

      #12;
      chk("rst_ready",     64'(bus.ready_o),       64'd1);
      chk("rst_valid",     64'(bus.valid_o),       64'd0);
      chk("rst_data",      64'(bus.data_o),        64'd0);
      chk("rst_chan",      64'(bus.chan_o),        64'd0);
      chk("rst_rdata",     64'(bus.coeff_rdata_o), 64'd0);
      chk("rst_drop",      64'(bus.coeff_drop_o),  64'd0);
      chk("rst_err",       64'(bus.chan_err_o),    64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int k = 0; k < TAPS; k++) write_coeff(4'(k), 16'(k + 1));
      @(negedge clk_i); bus.coeff_addr_i = 4'd5;
      @(posedge clk_i); #1;
      chk("readback_c5", 64'(bus.coeff_rdata_o), 64'd6);

      for (int i = 0; i < 49; i++) begin
         send(vecs[i].chan, vecs[i].data);
         wait_out(0, vecs[i].chan, vecs[i].exp, 1'b1, $sformatf("vec%0d", i));
      end

      // coefficient write two cycles after acceptance is dropped
      send(2'd2, 16'sd7);
      @(posedge clk_i);
      @(negedge clk_i);
      bus.coeff_we_i = 1'b1; bus.coeff_addr_i = 4'd3; bus.coeff_wdata_i = 16'sd5;
      @(posedge clk_i); #1;
      bus.coeff_we_i = 1'b0;
      chk("busy_drop",  64'(bus.coeff_drop_o),  64'd1);
      chk("busy_rdata", 64'(bus.coeff_rdata_o), 64'd4);
      wait_out(2, 2'd2, 32'sd7, 1'b1, "busy_out");
      write_coeff(4'd3, 16'sd5);
      chk("idle_wr_rdata", 64'(bus.coeff_rdata_o), 64'd5);
      chk("idle_wr_drop",  64'(bus.coeff_drop_o),  64'd0);
      write_coeff(4'd3, 16'sd4);

      // out-of-range channel
      @(negedge clk_i);
      bus.valid_i = 1'b1; bus.chan_i = 2'd3; bus.data_i = 16'sd555;
      @(posedge clk_i); #1;
      bus.valid_i = 1'b0;
      chk("bad_err",   64'(bus.chan_err_o), 64'd1);
      chk("bad_ready", 64'(bus.ready_o),    64'd1);
      @(posedge clk_i); #1;
      chk("bad_err_pulse", 64'(bus.chan_err_o), 64'd0);
      no_valid_for(20, "bad_no_valid");
      send(2'd2, 16'sd0);
      wait_out(0, 2'd2, 32'sd14, 1'b1, "after_bad");

      // reset at k=5 aborts; history, pointers and coefficients cleared
      send(2'd2, 16'sd50);
      repeat (5) @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_valid", 64'(bus.valid_o),       64'd0);
      chk("midrst_data",  64'(bus.data_o),        64'd0);
      chk("midrst_chan",  64'(bus.chan_o),        64'd0);
      chk("midrst_ready", 64'(bus.ready_o),       64'd1);
      chk("midrst_rdata", 64'(bus.coeff_rdata_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("postrst_c3", 64'(bus.coeff_rdata_o), 64'd0);
      no_valid_for(20, "midrst_no_valid");
      for (int k = 0; k < TAPS; k++) write_coeff(4'(k), 16'(k + 1));
      send(2'd2, 16'sd1);
      wait_out(0, 2'd2, 32'sd1, 1'b1, "postrst0");
      send(2'd2, 16'sd0);
      wait_out(0, 2'd2, 32'sd2, 1'b1, "postrst1");
      send(2'd2, 16'sd0);
      wait_out(0, 2'd2, 32'sd3, 1'b1, "postrst2");

      // full-scale accumulation: 16 * 0x7FFF^2 = 0x3_FFF0_0010
      for (int k = 0; k < TAPS; k++) write_coeff(4'(k), 16'sh7FFF);
      for (int i = 0; i < 16; i++) begin
         send(2'd0, 16'sh7FFF);
`ifdef FIR_MC_SAT_EN
         wait_out(0, 2'd0, 32'sh7FFFFFFF, (i == 15), $sformatf("sat%0d", i));
`else
         wait_out(0, 2'd0, 32'shFFF00010, (i == 15), $sformatf("sat%0d", i));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
